// File: rtl/peak_scan_pkg.sv
// -----------------------------------------------------------------------------
// peak_scan_pkg
// Shared definitions for the spectral peak scan controller.
//   - PS_ADDR_W / PS_DATA_W : default bin-index and magnitude widths. These
//     are also the widths serial_peak_finder is built with.
//   - scan_state_t          : controller FSM encoding (IDLE..DONE).
// No ports (package).
// -----------------------------------------------------------------------------
package peak_scan_pkg;

    localparam int PS_ADDR_W = 12;
    localparam int PS_DATA_W = 18;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DRAIN  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } scan_state_t;

endpackage

// File: rtl/scan_tag_pipe.sv
// -----------------------------------------------------------------------------
// scan_tag_pipe
// Carries a {vld, first} tag alongside each RAM read so that the finder sees
// enable/start exactly on the cycle its sample arrives. The tag is delayed
// RD_LAT cycles, which lines it up with mag_data. Tag and data are then
// registered together into the finder-facing outputs.
//
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   i_push            : an address is being issued this cycle
//   i_first           : the issued address is the first bin of the window
//   i_mag_data        : RAM read data (valid RD_LAT cycles after its address)
//   o_enable          : finder enable (sample valid)
//   o_start           : finder start (first sample of the window)
//   o_data            : finder sample, zero when o_enable is low
//   o_upstream_busy   : a tag is still in flight ahead of the final stage
// -----------------------------------------------------------------------------
module scan_tag_pipe #(
    parameter int RD_LAT = 2,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic              i_first,
    input  logic [DATA_W-1:0] i_mag_data,
    output logic              o_enable,
    output logic              o_start,
    output logic [DATA_W-1:0] o_data,
    output logic              o_upstream_busy
);

    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_first;
    logic [RD_LAT-1:0] w_vld_next;
    logic [RD_LAT-1:0] w_first_next;
    logic              r_enable;
    logic              r_start;
    logic [DATA_W-1:0] r_data;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign w_vld_next[gi]   = i_push;
                assign w_first_next[gi] = i_push & i_first;
            end else begin : g_tail
                assign w_vld_next[gi]   = r_vld[gi-1];
                assign w_first_next[gi] = r_first[gi-1];
            end
        end

        // The final stage is the one being presented next edge; only the
        // stages ahead of it count as "still in flight" for the drain test.
        if (RD_LAT > 1) begin : g_busy
            assign o_upstream_busy = |r_vld[RD_LAT-2:0];
        end else begin : g_nobusy
            assign o_upstream_busy = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld    <= '0;
            r_first  <= '0;
            r_enable <= 1'b0;
            r_start  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_vld    <= w_vld_next;
            r_first  <= w_first_next;
            r_enable <= r_vld[RD_LAT-1];
            r_start  <= r_vld[RD_LAT-1] & r_first[RD_LAT-1];
            // Zero the sample when invalid so no stale magnitude is visible.
            r_data   <= r_vld[RD_LAT-1] ? i_mag_data : '0;
        end
    end

    assign o_enable = r_enable;
    assign o_start  = r_start;
    assign o_data   = r_data;

endmodule

// File: rtl/peak_scan_controller.sv
// -----------------------------------------------------------------------------
// peak_scan_controller
// Runs one spectral peak search per FFT frame. On frame_ready it walks the
// magnitude RAM over [lo_bin, hi_bin]. The magnitudes are streamed into
// serial_peak_finder with start/enable framing. After RAM and finder latency
// have elapsed it publishes the absolute peak bin.
// Latency: frame_ready to peak_valid = (hi-lo+1)+RD_LAT+PF_LAT+2 cycles.
//
// Optional build macro: PEAK_SCAN_QUEUE_EN
//   defined   : a one-deep pending frame (with its own captured window) is
//               accepted while busy and started straight out of DONE.
//   undefined : frame_ready while busy is dropped and flagged via overrun.
//
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   frame_ready     : pulse, RAM holds a complete frame
//   lo_bin, hi_bin  : search window (inclusive), captured on acceptance
//   mag_addr        : RAM read address
//   mag_data        : RAM read data, RD_LAT cycles after mag_addr
//   pf_enable/start : finder sample framing
//   pf_data         : finder sample
//   pf_peak_index   : finder result, relative to first sample
//   peak_valid      : pulse, peak_index updated
//   peak_index      : absolute peak bin, held between frames
//   busy            : a frame is being processed (through DONE)
//   cfg_err         : pulse, window rejected (lo > hi)
//   overrun         : sticky, a frame was dropped
// -----------------------------------------------------------------------------
module peak_scan_controller
    import peak_scan_pkg::*;
#(
    parameter int ADDR_W = PS_ADDR_W,
    parameter int DATA_W = PS_DATA_W,
    parameter int RD_LAT = 2,
    parameter int PF_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_ready,
    input  logic [ADDR_W-1:0] lo_bin,
    input  logic [ADDR_W-1:0] hi_bin,
    output logic [ADDR_W-1:0] mag_addr,
    input  logic [DATA_W-1:0] mag_data,
    output logic              pf_enable,
    output logic              pf_start,
    output logic [DATA_W-1:0] pf_data,
    input  logic [ADDR_W-1:0] pf_peak_index,
    output logic              peak_valid,
    output logic [ADDR_W-1:0] peak_index,
    output logic              busy,
    output logic              cfg_err,
    output logic              overrun
);

    localparam int CNT_W = (PF_LAT > 1) ? $clog2(PF_LAT) : 1;

    scan_state_t       r_state;
    scan_state_t       w_state_next;

    logic [ADDR_W-1:0] r_mag_addr;
    logic [ADDR_W-1:0] r_lo_cap;
    logic [ADDR_W-1:0] r_hi_cap;
    logic [ADDR_W-1:0] r_peak_index;
    logic              r_rejected;
    logic              r_peak_valid;
    logic              r_cfg_err;
    logic              r_overrun;
    logic [CNT_W-1:0]  r_settle_cnt;

    logic              w_start;
    logic [ADDR_W-1:0] w_start_lo;
    logic [ADDR_W-1:0] w_start_hi;
    logic              w_overrun_set;
    logic              w_push;
    logic              w_first;
    logic              w_upstream_busy;

`ifdef PEAK_SCAN_QUEUE_EN
    logic              r_pending;
    logic [ADDR_W-1:0] r_pend_lo;
    logic [ADDR_W-1:0] r_pend_hi;
    logic              w_pend_set;
    logic              w_pend_clr;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and frame acceptance
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_start_lo    = lo_bin;
        w_start_hi    = hi_bin;
        w_overrun_set = 1'b0;
`ifdef PEAK_SCAN_QUEUE_EN
        w_pend_set    = 1'b0;
        w_pend_clr    = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                if (frame_ready) begin
                    w_start = 1'b1;
                end
            end
            SCAN: begin
                if (r_mag_addr == r_hi_cap) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_upstream_busy) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == CNT_W'(PF_LAT - 1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
`ifdef PEAK_SCAN_QUEUE_EN
                // Chain straight into the next scan. A frame arriving on this
                // cycle with no pending frame is taken directly. A frame
                // arriving while one is pending is dropped.
                if (r_pending) begin
                    w_start    = 1'b1;
                    w_start_lo = r_pend_lo;
                    w_start_hi = r_pend_hi;
                    w_pend_clr = 1'b1;
                    if (frame_ready) begin
                        w_overrun_set = 1'b1;
                    end
                end else if (frame_ready) begin
                    w_start = 1'b1;
                end
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (frame_ready && (r_state != IDLE)) begin
`ifdef PEAK_SCAN_QUEUE_EN
            if (r_state != DONE) begin
                if (r_pending) begin
                    w_overrun_set = 1'b1;
                end else begin
                    w_pend_set = 1'b1;
                end
            end
`else
            w_overrun_set = 1'b1;
`endif
        end

        if (w_start) begin
            w_state_next = (w_start_lo > w_start_hi) ? DONE : SCAN;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: window capture, address walk, settle count, result publish
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mag_addr   <= '0;
            r_lo_cap     <= '0;
            r_hi_cap     <= '0;
            r_peak_index <= '0;
            r_rejected   <= 1'b0;
            r_peak_valid <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_overrun    <= 1'b0;
            r_settle_cnt <= '0;
        end else begin
            r_peak_valid <= 1'b0;
            r_cfg_err    <= 1'b0;

            if (w_start) begin
                r_lo_cap   <= w_start_lo;
                r_hi_cap   <= w_start_hi;
                r_rejected <= (w_start_lo > w_start_hi);
                if (w_start_lo <= w_start_hi) begin
                    r_mag_addr <= w_start_lo;
                end
            end else if ((r_state == SCAN) && (r_mag_addr != r_hi_cap)) begin
                r_mag_addr <= r_mag_addr + ADDR_W'(1);
            end

            // DONE reads the old lo_cap even when a chained scan reloads it.
            if (r_state == DONE) begin
                if (r_rejected) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_peak_valid <= 1'b1;
                    r_peak_index <= r_lo_cap + pf_peak_index;
                end
            end

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end

            if (r_state == SETTLE) begin
                r_settle_cnt <= r_settle_cnt + CNT_W'(1);
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

`ifdef PEAK_SCAN_QUEUE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
            r_pend_lo <= '0;
            r_pend_hi <= '0;
        end else begin
            if (w_pend_set) begin
                r_pending <= 1'b1;
                r_pend_lo <= lo_bin;
                r_pend_hi <= hi_bin;
            end else if (w_pend_clr) begin
                r_pending <= 1'b0;
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Sample framing toward the finder
    // -------------------------------------------------------------------------
    assign w_push  = (r_state == SCAN);
    assign w_first = (r_mag_addr == r_lo_cap);

    scan_tag_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_tag_pipe (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_push          (w_push),
        .i_first         (w_first),
        .i_mag_data      (mag_data),
        .o_enable        (pf_enable),
        .o_start         (pf_start),
        .o_data          (pf_data),
        .o_upstream_busy (w_upstream_busy)
    );

    assign mag_addr   = r_mag_addr;
    assign peak_valid = r_peak_valid;
    assign peak_index = r_peak_index;
    assign busy       = (r_state != IDLE);
    assign cfg_err    = r_cfg_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_peak_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_peak_scan_controller
// Directed bench for peak_scan_controller. It includes a RAM model (2-cycle
// read latency) and a serial peak finder model (result stable 2 cycles after
// the last sample). Each scenario task drives a frame and compares the
// observed counts, timing and result against hand-computed values.
// -----------------------------------------------------------------------------
module tb_peak_scan_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_ready = 1'b0;
    logic [11:0] lo_bin = '0;
    logic [11:0] hi_bin = '0;
    logic [11:0] mag_addr;
    logic [17:0] mag_data = '0;
    logic        pf_enable;
    logic        pf_start;
    logic [17:0] pf_data;
    logic [11:0] pf_peak_index = '0;
    logic        peak_valid;
    logic [11:0] peak_index;
    logic        busy;
    logic        cfg_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peak_scan_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_ready   (frame_ready),
        .lo_bin        (lo_bin),
        .hi_bin        (hi_bin),
        .mag_addr      (mag_addr),
        .mag_data      (mag_data),
        .pf_enable     (pf_enable),
        .pf_start      (pf_start),
        .pf_data       (pf_data),
        .pf_peak_index (pf_peak_index),
        .peak_valid    (peak_valid),
        .peak_index    (peak_index),
        .busy          (busy),
        .cfg_err       (cfg_err),
        .overrun       (overrun)
    );

    // RAM model: address registered, then data registered (2-cycle latency).
    logic [17:0] mem [4096];
    logic [11:0] ram_a = '0;
    always @(posedge clk) begin
        ram_a    <= mag_addr;
        mag_data <= mem[ram_a];
    end

    // Finder model: first strict maximum, index relative to the start sample.
    logic [11:0] f_cnt  = '0;
    logic [11:0] f_idx  = '0;
    logic [17:0] f_best = '0;
    always @(posedge clk) begin
        if (pf_enable) begin
            if (pf_start) begin
                f_cnt  <= 12'd1;
                f_best <= pf_data;
                f_idx  <= '0;
            end else begin
                f_cnt <= f_cnt + 12'd1;
                if (pf_data > f_best) begin
                    f_best <= pf_data;
                    f_idx  <= f_cnt;
                end
            end
        end
        pf_peak_index <= f_idx;
    end

    // Monitor, sampled on the falling edge.
    int cyc = 0;
    int en_cnt = 0, start_cnt = 0, both_cnt = 0, pv_cnt = 0, cfg_cnt = 0;
    int pv_cyc = 0, cfg_cyc = 0;
    logic busy_at_pv = 1'b0, busy_before_pv = 1'b0, prev_busy = 1'b0;
    always @(negedge clk) begin
        if (pf_enable) en_cnt <= en_cnt + 1;
        if (pf_start) start_cnt <= start_cnt + 1;
        if (pf_start && pf_enable) both_cnt <= both_cnt + 1;
        if (peak_valid) begin
            pv_cnt         <= pv_cnt + 1;
            pv_cyc         <= cyc;
            busy_at_pv     <= busy;
            busy_before_pv <= prev_busy;
        end
        if (cfg_err) begin
            cfg_cnt <= cfg_cnt + 1;
            cfg_cyc <= cyc;
        end
        prev_busy <= busy;
        cyc <= cyc + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses frame_ready for one cycle; c0 is that cycle's monitor label.
    task automatic drive_frame(input logic [11:0] lo, input logic [11:0] hi, output int c0);
        @(posedge clk);
        #1;
        lo_bin = lo;
        hi_bin = hi;
        frame_ready = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_cycles(3);
        checks++; if (mag_addr !== 12'd0) begin errors++; $display("FAIL reset_mag_addr got %0d want 0", mag_addr); end
        checks++; if (pf_enable !== 1'b0 || pf_start !== 1'b0) begin errors++; $display("FAIL reset_pf got en=%b st=%b want 0", pf_enable, pf_start); end
        checks++; if (peak_valid !== 1'b0 || peak_index !== 12'd0) begin errors++; $display("FAIL reset_peak got v=%b idx=%0d want 0", peak_valid, peak_index); end
        checks++; if (busy !== 1'b0 || cfg_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b cfg=%b ovr=%b want 0", busy, cfg_err, overrun); end
        reset_n = 1'b1;
        wait_cycles(2);
        $display("reset: done");
    endtask

    task automatic test_scan(input string name, input int lo, input int hi, input int exp_idx);
        int c0, en0, st0, bo0, pv0, n;
        n = hi - lo + 1;
        en0 = en_cnt; st0 = start_cnt; bo0 = both_cnt; pv0 = pv_cnt;
        drive_frame(lo[11:0], hi[11:0], c0);
        // Window changes after acceptance must not affect the scan.
        lo_bin = 12'd0;
        hi_bin = 12'd5;
        wait_cycles(n + 12);
        checks++; if (en_cnt - en0 !== n) begin errors++; $display("FAIL %s_enables got %0d want %0d", name, en_cnt - en0, n); end
        checks++; if (start_cnt - st0 !== 1 || both_cnt - bo0 !== 1) begin errors++; $display("FAIL %s_start got %0d/%0d want 1/1", name, start_cnt - st0, both_cnt - bo0); end
        checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL %s_valid_count got %0d want 1", name, pv_cnt - pv0); end
        checks++; if (pv_cyc - c0 !== n + 6) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, pv_cyc - c0, n + 6); end
        checks++; if (peak_index !== exp_idx[11:0]) begin errors++; $display("FAIL %s_peak_index got %0d want %0d", name, peak_index, exp_idx); end
        checks++; if (busy_at_pv !== 1'b0 || busy_before_pv !== 1'b1) begin errors++; $display("FAIL %s_busy_edge got done=%b after=%b want 1/0", name, busy_before_pv, busy_at_pv); end
        $display("%s: lo=%0d hi=%0d peak_index=%0d latency=%0d", name, lo, hi, peak_index, pv_cyc - c0);
    endtask

    task automatic test_reject();
        int c0, en0, pv0, cf0;
        logic [11:0] held;
        held = peak_index;
        en0 = en_cnt; pv0 = pv_cnt; cf0 = cfg_cnt;
        drive_frame(12'd300, 12'd200, c0);
        wait_cycles(10);
        checks++; if (cfg_cnt - cf0 !== 1 || cfg_cyc - c0 !== 2) begin errors++; $display("FAIL reject_cfg_err got n=%0d at=%0d want 1 at 2", cfg_cnt - cf0, cfg_cyc - c0); end
        checks++; if (en_cnt - en0 !== 0 || pv_cnt - pv0 !== 0) begin errors++; $display("FAIL reject_activity got en=%0d pv=%0d want 0/0", en_cnt - en0, pv_cnt - pv0); end
        checks++; if (peak_index !== held) begin errors++; $display("FAIL reject_hold got %0d want %0d", peak_index, held); end
        $display("reject: lo=300 hi=200 cfg_err seen, peak_index=%0d", peak_index);
    endtask

    task automatic test_back_to_back();
        int c0, pv0;
        pv0 = pv_cnt;
        drive_frame(12'd0, 12'd40, c0);
        wait_cycles(8);
        lo_bin = 12'd5;
        hi_bin = 12'd9;
        frame_ready = 1'b1;
        wait_cycles(1);
        frame_ready = 1'b0;
        wait_cycles(80);
`ifdef PEAK_SCAN_QUEUE_EN
        checks++; if (pv_cnt - pv0 !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d want 2", pv_cnt - pv0); end
        checks++; if (pv_cyc - c0 !== 57) begin errors++; $display("FAIL b2b_second_latency got %0d want 57", pv_cyc - c0); end
        checks++; if (peak_index !== 12'd9) begin errors++; $display("FAIL b2b_peak_index got %0d want 9", peak_index); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun); end
`else
        checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL b2b_valid_count got %0d want 1", pv_cnt - pv0); end
        checks++; if (pv_cyc - c0 !== 47) begin errors++; $display("FAIL b2b_latency got %0d want 47", pv_cyc - c0); end
        checks++; if (peak_index !== 12'd40) begin errors++; $display("FAIL b2b_peak_index got %0d want 40", peak_index); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", overrun); end
`endif
        $display("back_to_back: peak_valid pulses=%0d peak_index=%0d overrun=%b", pv_cnt - pv0, peak_index, overrun);
    endtask

    task automatic test_mid_reset();
        int c0, pv0;
        pv0 = pv_cnt;
        drive_frame(12'd0, 12'd100, c0);
        wait_cycles(19);
        checks++; if (mag_addr !== 12'd19 || pf_enable !== 1'b1) begin errors++; $display("FAIL midrst_before got addr=%0d en=%b want 19/1", mag_addr, pf_enable); end
        reset_n = 1'b0;
        #1;
        checks++; if (mag_addr !== 12'd0 || pf_enable !== 1'b0 || pf_data !== 18'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_outputs got addr=%0d en=%b data=%0d busy=%b want 0", mag_addr, pf_enable, pf_data, busy); end
        checks++; if (overrun !== 1'b0 || peak_index !== 12'd0) begin errors++; $display("FAIL midrst_regs got ovr=%b idx=%0d want 0/0", overrun, peak_index); end
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(120);
        checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL midrst_no_valid got %0d want 0", pv_cnt - pv0); end
        $display("mid_reset: scan aborted, peak_valid pulses=%0d", pv_cnt - pv0);
        test_scan("after_reset", 10, 30, 30);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 18'(i);
        test_reset();
        test_scan("full_window", 0, 4095, 4095);
        mem[100] = 18'h3FFFF;
        test_scan("peak_100", 50, 200, 100);
        mem[100] = 18'd100;
        test_scan("single_bin", 7, 7, 7);
        test_reject();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
